// File: rtl/parity_frame_pkg.sv
// Shared definitions for the XOR-parity frame path (receiver and transmitter).
//   state_t    : receiver FSM states
//   START_BIT  : line level of a start bit
//   STOP_BIT   : line level of a stop bit
//   parity_of  : parity bit a transmitter sends for a word (zero-extended to 32 bits)
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity: XOR of the data. Odd parity: its complement.
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_rx.sv
// Serial receiver/checker for XOR-parity frames.
// Frame on the line, LSB first: start(0), DATA_W data bits, parity bit, stop(1).
// Bits are consumed only in cycles with bit_valid=1; gaps of any length are allowed.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   bit_in     : serial frame bit
//   bit_valid  : qualifies bit_in
//   data_out   : last good-stop data word (bit 0 = first data bit received)
//   data_valid : one-cycle pulse, frame completed with a good stop bit
//   parity_err : qualifies data_valid, recomputed parity mismatched
//   frame_err  : one-cycle pulse, stop bit was 0
//   busy       : high whenever the FSM is not IDLE
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xor_q, xor_d;
  logic              mismatch_q, mismatch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    mismatch_d   = mismatch_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (bit_in == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
            xor_d   = 1'b0;
          end
        end
        DATA: begin
          // Enter at the MSB so that after DATA_W shifts the first bit sits at bit 0.
          // Written as shift-then-set so it also elaborates for DATA_W=1.
          shift_d             = shift_q >> 1;
          shift_d[DATA_W-1]   = bit_in;
          xor_d               = xor_q ^ bit_in;
          cnt_d               = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          mismatch_d = bit_in ^ xor_q ^ PARITY_ODD;
          state_d    = STOP;
        end
        STOP: begin
          if (bit_in == STOP_BIT) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = mismatch_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      xor_q        <= 1'b0;
      mismatch_q   <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      mismatch_q   <= mismatch_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity instance
// share the same serial stimulus; expected values are hand-computed constants.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b1;
  logic       bit_valid = 1'b0;

  logic [7:0] data_out_e, data_out_o;
  logic       data_valid_e, data_valid_o;
  logic       parity_err_e, parity_err_o;
  logic       frame_err_e, frame_err_o;
  logic       busy_e, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out_e), .data_valid(data_valid_e), .parity_err(parity_err_e),
    .frame_err(frame_err_e), .busy(busy_e)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out_o), .data_valid(data_valid_o), .parity_err(parity_err_o),
    .frame_err(frame_err_o), .busy(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Idle `gap` cycles with bit_valid=0, then one qualified bit; returns #1 after its edge.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_valid = 1'b0;
      @(posedge clk); #1;
    end
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int gap, input bit chk_busy);
    send_bit(1'b0, gap);
    if (chk_busy) check("busy_after_start", busy_e, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    if (chk_busy) check("busy_in_stop", busy_e, 1);
    send_bit(stp, gap);
    if (chk_busy) check("busy_after_stop", busy_e, 0);
  endtask

  task automatic check_even(input string tag, input logic dv, input logic pe,
                            input logic fe, input logic [7:0] d);
    check({tag, "_dv"}, data_valid_e, dv);
    check({tag, "_pe"}, parity_err_e, pe);
    check({tag, "_fe"}, frame_err_e, fe);
    check({tag, "_data"}, data_out_e, d);
    $display("frame %s: data_out=0x%02h dv=%0b pe=%0b fe=%0b", tag, data_out_e,
             data_valid_e, parity_err_e, frame_err_e);
  endtask

  task automatic idle_cycle();
    bit_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_even("reset", 0, 0, 0, 8'h00);
    check("reset_busy", busy_e, 0);

    // 0xA5, even parity bit 0, good stop
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    check_even("a5_good", 1, 0, 0, 8'hA5);
    idle_cycle();
    check("a5_pulse_one_cycle", data_valid_e, 0);

    // 0xA5 with wrong parity bit: data still delivered
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check_even("a5_bad_par", 1, 1, 0, 8'hA5);
    idle_cycle();

    // 0x3C with stop bit 0: frame error, data_out keeps 0xA5
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    check_even("3c_frame_err", 0, 0, 1, 8'hA5);
    idle_cycle();
    check("3c_fe_one_cycle", frame_err_e, 0);

    // Back-to-back 0x01 (parity 1) then 0xFE (parity 1)
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    check_even("b2b_01", 1, 0, 0, 8'h01);
    send_frame(8'hFE, 1'b1, 1'b1, 0, 1'b0);
    check_even("b2b_fe", 1, 0, 0, 8'hFE);
    idle_cycle();

    // Leading idle ones, then 0x81 (parity 0) with two-cycle gaps before each bit
    repeat (3) send_bit(1'b1, 0);
    check("idle_ones_busy", busy_e, 0);
    send_frame(8'h81, 1'b0, 1'b1, 2, 1'b1);
    check_even("81_gaps", 1, 0, 0, 8'h81);
    idle_cycle();

    // Abort mid-frame with reset after the 4th data bit
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    check_even("abort_reset", 0, 0, 0, 8'h00);
    check("abort_busy", busy_e, 0);
    repeat (6) idle_cycle();
    check("abort_no_pulse", data_valid_e | frame_err_e, 0);

    // 0x55 even parity bit 0
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
    check_even("55_even", 1, 0, 0, 8'h55);
    check("55_odd_inst_pe", parity_err_o, 1);
    idle_cycle();

    // 0x55 with parity bit 1: wrong for even, right for odd
    send_frame(8'h55, 1'b1, 1'b1, 0, 1'b0);
    check_even("55_p1_even", 1, 1, 0, 8'h55);
    check("55_odd_dv", data_valid_o, 1);
    check("55_odd_pe", parity_err_o, 0);
    check("55_odd_data", data_out_o, 8'h55);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
